// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register with stall, flush and branch redirect.
// pc drives instruction memory directly; instr_in is expected back in the same cycle.
module fetch_stage #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     PC_STEP     = 1,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    if_pc_out,
  output logic [PC_WIDTH-1:0]    if_pc_next_out,
  output logic [INSTR_WIDTH-1:0] if_instr_out,
  output logic                   if_valid_out
);

  localparam logic [PC_WIDTH-1:0] PC_STEP_W = PC_WIDTH'(PC_STEP);

  logic [PC_WIDTH-1:0] pc_plus;

  // Modulo 2^PC_WIDTH; the carry out is dropped on purpose.
  assign pc_plus = pc + PC_STEP_W;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (branch_taken) begin
      pc <= branch_target;
    end else if (!stall) begin
      pc <= pc_plus;
    end
  end

  // A redirect always bubbles IF/ID, even under stall, so the wrong-path word never reaches decode.
  always_ff @(posedge clock) begin
    if (reset || flush || branch_taken) begin
      if_pc_out      <= '0;
      if_pc_next_out <= '0;
      if_instr_out   <= NOP_INSTR;
      if_valid_out   <= 1'b0;
    end else if (!stall) begin
      if_pc_out      <= pc;
      if_pc_next_out <= pc_plus;
      if_instr_out   <= instr_in;
      if_valid_out   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an 8-bit word-addressed instance and a 16-bit byte-addressed one.
// Instruction memory is modelled as instr = zero-extended address.
module tb_fetch_stage;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [31:0] NOP_A = 32'h0000_0013;

  // instance A: PC_WIDTH=8, PC_STEP=1, RESET_PC=0
  logic        a_reset, a_stall, a_flush, a_branch;
  logic [7:0]  a_target;
  logic [31:0] a_instr;
  logic [7:0]  a_pc, a_if_pc, a_if_pc_next;
  logic [31:0] a_if_instr;
  logic        a_if_valid;

  // instance B: PC_WIDTH=16, PC_STEP=4, RESET_PC=16'h0100
  logic        b_reset, b_stall, b_flush, b_branch;
  logic [15:0] b_target;
  logic [31:0] b_instr;
  logic [15:0] b_pc, b_if_pc, b_if_pc_next;
  logic [31:0] b_if_instr;
  logic        b_if_valid;

  assign a_instr = {24'h0, a_pc};
  assign b_instr = {16'h0, b_pc};

  fetch_stage #(
    .PC_WIDTH(8), .INSTR_WIDTH(32), .PC_STEP(1), .RESET_PC(8'h00), .NOP_INSTR(NOP_A)
  ) dut_a (
    .clock(clock), .reset(a_reset), .stall(a_stall), .flush(a_flush),
    .branch_taken(a_branch), .branch_target(a_target), .instr_in(a_instr),
    .pc(a_pc), .if_pc_out(a_if_pc), .if_pc_next_out(a_if_pc_next),
    .if_instr_out(a_if_instr), .if_valid_out(a_if_valid)
  );

  fetch_stage #(
    .PC_WIDTH(16), .INSTR_WIDTH(32), .PC_STEP(4), .RESET_PC(16'h0100), .NOP_INSTR(32'h0)
  ) dut_b (
    .clock(clock), .reset(b_reset), .stall(b_stall), .flush(b_flush),
    .branch_taken(b_branch), .branch_target(b_target), .instr_in(b_instr),
    .pc(b_pc), .if_pc_out(b_if_pc), .if_pc_next_out(b_if_pc_next),
    .if_instr_out(b_if_instr), .if_valid_out(b_if_valid)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic edge_a;
    @(posedge clock);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [7:0] e_pc, input logic [7:0] e_if_pc,
                         input logic [7:0] e_next, input logic [31:0] e_instr, input logic e_valid);
    check({tag, ".pc"},      64'(a_pc),         64'(e_pc));
    check({tag, ".if_pc"},   64'(a_if_pc),      64'(e_if_pc));
    check({tag, ".if_next"}, 64'(a_if_pc_next), 64'(e_next));
    check({tag, ".instr"},   64'(a_if_instr),   64'(e_instr));
    check({tag, ".valid"},   64'(a_if_valid),   64'(e_valid));
  endtask

  task automatic check_b(input string tag, input logic [15:0] e_pc, input logic [15:0] e_if_pc,
                         input logic [15:0] e_next, input logic [31:0] e_instr, input logic e_valid);
    check({tag, ".pc"},      64'(b_pc),         64'(e_pc));
    check({tag, ".if_pc"},   64'(b_if_pc),      64'(e_if_pc));
    check({tag, ".if_next"}, 64'(b_if_pc_next), 64'(e_next));
    check({tag, ".instr"},   64'(b_if_instr),   64'(e_instr));
    check({tag, ".valid"},   64'(b_if_valid),   64'(e_valid));
  endtask

  initial begin
    a_reset = 1'b1; a_stall = 1'b0; a_flush = 1'b0; a_branch = 1'b0; a_target = 8'h00;
    b_reset = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_branch = 1'b0; b_target = 16'h0000;

    edge_a;
    edge_a;
    check_a("a_reset", 8'h00, 8'h00, 8'h00, NOP_A, 1'b0);

    a_reset = 1'b0;
    edge_a; check_a("a_run1", 8'h01, 8'h00, 8'h01, 32'h00, 1'b1);
    edge_a; check_a("a_run2", 8'h02, 8'h01, 8'h02, 32'h01, 1'b1);
    edge_a; check_a("a_run3", 8'h03, 8'h02, 8'h03, 32'h02, 1'b1);
    edge_a;
    edge_a; check_a("a_run5", 8'h05, 8'h04, 8'h05, 32'h04, 1'b1);

    a_stall = 1'b1;
    edge_a; check_a("a_stall1", 8'h05, 8'h04, 8'h05, 32'h04, 1'b1);
    edge_a; check_a("a_stall2", 8'h05, 8'h04, 8'h05, 32'h04, 1'b1);
    edge_a; check_a("a_stall3", 8'h05, 8'h04, 8'h05, 32'h04, 1'b1);
    a_stall = 1'b0;
    edge_a; check_a("a_unstall", 8'h06, 8'h05, 8'h06, 32'h05, 1'b1);

    edge_a; edge_a; edge_a; edge_a;
    check({"a_at10"}, 64'(a_pc), 64'h0A);

    a_branch = 1'b1; a_target = 8'h40;
    edge_a; check_a("a_branch", 8'h40, 8'h00, 8'h00, NOP_A, 1'b0);
    a_branch = 1'b0;
    edge_a; check_a("a_branch_next", 8'h41, 8'h40, 8'h41, 32'h40, 1'b1);

    a_branch = 1'b1; a_stall = 1'b1; a_target = 8'h20;
    edge_a; check_a("a_br_stall", 8'h20, 8'h00, 8'h00, NOP_A, 1'b0);
    a_branch = 1'b0; a_stall = 1'b0;
    edge_a; check_a("a_br_stall_next", 8'h21, 8'h20, 8'h21, 32'h20, 1'b1);

    a_flush = 1'b1; a_stall = 1'b1;
    edge_a; check_a("a_flush_stall", 8'h21, 8'h00, 8'h00, NOP_A, 1'b0);
    a_flush = 1'b0; a_stall = 1'b0;
    edge_a; check_a("a_flush_stall_next", 8'h22, 8'h21, 8'h22, 32'h21, 1'b1);

    a_flush = 1'b1;
    edge_a; check_a("a_flush_only", 8'h23, 8'h00, 8'h00, NOP_A, 1'b0);
    a_flush = 1'b0;

    a_branch = 1'b1; a_target = 8'hFE;
    edge_a; check_a("a_wrap0", 8'hFE, 8'h00, 8'h00, NOP_A, 1'b0);
    a_branch = 1'b0;
    edge_a; check_a("a_wrap1", 8'hFF, 8'hFE, 8'hFF, 32'hFE, 1'b1);
    edge_a; check_a("a_wrap2", 8'h00, 8'hFF, 8'h00, 32'hFF, 1'b1);
    edge_a; check_a("a_wrap3", 8'h01, 8'h00, 8'h01, 32'h00, 1'b1);

    a_reset = 1'b1; a_stall = 1'b1; a_branch = 1'b1; a_flush = 1'b1; a_target = 8'h77;
    edge_a; check_a("a_midreset", 8'h00, 8'h00, 8'h00, NOP_A, 1'b0);
    a_reset = 1'b0; a_stall = 1'b0; a_branch = 1'b0; a_flush = 1'b0;
    edge_a; check_a("a_after_reset", 8'h01, 8'h00, 8'h01, 32'h00, 1'b1);

    check_b("b_reset", 16'h0100, 16'h0000, 16'h0000, 32'h0, 1'b0);
    b_reset = 1'b0;
    edge_a; check_b("b_run1", 16'h0104, 16'h0100, 16'h0104, 32'h0100, 1'b1);
    edge_a; check_b("b_run2", 16'h0108, 16'h0104, 16'h0108, 32'h0104, 1'b1);

    b_branch = 1'b1; b_target = 16'hFFFC;
    edge_a; check_b("b_br", 16'hFFFC, 16'h0000, 16'h0000, 32'h0, 1'b0);
    b_branch = 1'b0;
    edge_a; check_b("b_wrap", 16'h0000, 16'hFFFC, 16'h0000, 32'hFFFC, 1'b1);

    b_reset = 1'b1; b_stall = 1'b1; b_branch = 1'b1; b_target = 16'h1234;
    edge_a; check_b("b_midreset", 16'h0100, 16'h0000, 16'h0000, 32'h0, 1'b0);
    b_reset = 1'b0; b_stall = 1'b0; b_branch = 1'b0;
    edge_a; check_b("b_seq1", 16'h0104, 16'h0100, 16'h0104, 32'h0100, 1'b1);
    edge_a; check_b("b_seq2", 16'h0108, 16'h0104, 16'h0108, 32'h0104, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Parametrised instruction-fetch stage: the PC register plus the IF/ID pipeline register, with stall, flush and branch redirect. Drives the instruction-memory address combinationally from the PC. Captures {pc, pc+step, instruction, valid} into the IF/ID register for the decode stage. Successor to the plain 8-bit PC latch; adds width generality, hazard control and a valid bit.

Parameters:
PC_WIDTH, 8, width of PC and all PC-carrying ports
INSTR_WIDTH, 32, width of fetched instruction word
PC_STEP, 1, sequential PC increment (1 = word-addressed, 4 = byte-addressed)
RESET_PC, 0, PC value loaded on reset
NOP_INSTR, 0, instruction word injected on flush/reset

Ports:
clock  in  1  single clock, all state updates on rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard unit: hold PC and IF/ID contents
flush  in  1  invalidate IF/ID contents (bubble)
branch_taken  in  1  redirect PC to branch_target this cycle
branch_target  in  PC_WIDTH  redirect address
instr_in  in  INSTR_WIDTH  instruction memory read data for address pc
pc  out  PC_WIDTH  current PC; combinational address to instruction memory
if_pc_out  out  PC_WIDTH  registered PC of instruction in IF/ID
if_pc_next_out  out  PC_WIDTH  registered pc+PC_STEP of that instruction
if_instr_out  out  INSTR_WIDTH  registered instruction
if_valid_out  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (sampled on rising clock edge only; no async path): pc <= RESET_PC; if_pc_out <= 0; if_pc_next_out <= 0; if_instr_out <= NOP_INSTR; if_valid_out <= 0. Reset overrides every other input.
- PC register, priority highest first: reset; branch_taken -> pc <= branch_target; stall -> pc holds; else pc <= pc + PC_STEP.
- PC arithmetic modulo 2^PC_WIDTH; increment past max wraps silently (e.g. 8'hFF + 1 -> 8'h00), no flag.
- IF/ID register, priority highest first: reset; flush OR branch_taken -> if_instr_out <= NOP_INSTR, if_valid_out <= 0, if_pc_out/if_pc_next_out <= 0; stall -> all IF/ID outputs hold; else if_pc_out <= pc, if_pc_next_out <= pc + PC_STEP (wrapped), if_instr_out <= instr_in, if_valid_out <= 1.
- Branch during stall: redirect wins for PC, IF/ID is bubbled; no redirect is lost or deferred.
- Flush with stall (no branch): IF/ID bubbled, PC holds.
- instr_in is treated as valid in the same cycle pc is presented (combinational/asynchronous-read instruction memory); latency pc -> if_instr_out is one clock.
- First edge after reset deasserts: IF/ID captures RESET_PC with valid=1; pc advances to RESET_PC+PC_STEP.
- Reset asserted mid-stream: state returns to reset values on that edge regardless of stall/flush/branch; pending redirects discarded.
- No combinational path from any input to any output except pc (register output, no input dependence).

Test Plan:
- Reset then free-run, PC_WIDTH=8, PC_STEP=1, instr_in = {24'h0, pc}: during reset pc=0, if_valid_out=0; after release edges 1..3 show if_pc_out=0,1,2, if_instr_out=0,1,2, if_pc_next_out=1,2,3, valid=1.
- Stall for 3 cycles at pc=5: pc stays 5, IF/ID holds pc=4 entry unchanged; on release next edge captures pc=5.
- branch_taken with branch_target=8'h40 at pc=10: next edge pc=8'h40, if_valid_out=0, if_instr_out=NOP; following edge if_pc_out=8'h40, valid=1.
- branch_taken and stall together, target 8'h20: pc=8'h20 next edge, IF/ID bubbled; flush+stall without branch: pc holds, valid=0.
- Wrap: force pc to 8'hFE via branch, run free: pc sequence FE, FF, 00, 01; if_pc_next_out for FF entry = 00.
- Reset asserted mid-run with stall=1, branch_taken=1: single edge yields pc=RESET_PC, all IF/ID outputs at reset values; repeat with PC_STEP=4, PC_WIDTH=16, RESET_PC=16'h0100: sequence 0100, 0104, 0108.
